// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source count, register offsets
// and the fixed-priority encoder used for irq_id.
package irq_pkg;

    localparam int N_SRC = 8;

    localparam logic [31:0] OFF_PENDING = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK    = 32'h0000_0004;
    localparam logic [31:0] OFF_OVERRUN = 32'h0000_0008;
    localparam logic [31:0] OFF_ACTIVE  = 32'h0000_000C;
    localparam logic [31:0] OFF_SWSET   = 32'h0000_0010;

    // Lowest set index wins; returns 0 for an all-zero vector.
    function automatic logic [2:0] prio_enc(input logic [N_SRC-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchronizer followed by a rising-edge detector.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic irq_in,
    output logic rise
);

    logic sync_w;
    logic edge_q;
    logic edge_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_w = irq_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            logic [SYNC_STAGES-1:0] sync_d;
            logic [SYNC_STAGES:0]   chain;

            assign chain = {sync_q, irq_in};

            always_comb begin
                sync_d = chain[SYNC_STAGES-1:0];
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= sync_d;
            end

            assign sync_w = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    always_comb begin
        edge_d = sync_w;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_q <= 1'b0;
        else          edge_q <= edge_d;
    end

    assign rise = sync_w & ~edge_q;

endmodule

// File: rtl/irq_ctrl.sv
// Eight-source edge-triggered interrupt controller with a memory-mapped register
// window (pending/mask/overrun/active/swset) and fixed priority, bit 0 highest.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'hFFFF_FF00,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [31:0]      dataadr,
    input  logic [31:0]      writedata,
    input  logic             memwrite,
    output logic [31:0]      readdata,
    output logic [N_SRC-1:0] interrupts,
    output logic [2:0]       irq_id,
    output logic             irq_valid
);

    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] overrun_q, overrun_d;
    logic [N_SRC-1:0] interrupts_q, interrupts_d;
    logic [N_SRC-1:0] pend_clr, ovr_clr, sw_set;
    logic             unused_wdata;

    assign unused_wdata = ^writedata[31:N_SRC];

    generate
        for (genvar g = 0; g < N_SRC; g++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync_edge (
                .clk     (clk),
                .reset_n (reset_n),
                .irq_in  (irq_in[g]),
                .rise    (rise[g])
            );
        end
    endgenerate

    // Sets are OR-ed in after clears so a same-cycle set always wins.
    always_comb begin
        pend_clr = '0;
        ovr_clr  = '0;
        sw_set   = '0;
        mask_d   = mask_q;
        if (memwrite) begin
            if (dataadr == BASE + OFF_PENDING) pend_clr = writedata[N_SRC-1:0];
            if (dataadr == BASE + OFF_OVERRUN) ovr_clr  = writedata[N_SRC-1:0];
            if (dataadr == BASE + OFF_SWSET)   sw_set   = writedata[N_SRC-1:0];
            if (dataadr == BASE + OFF_MASK)    mask_d   = writedata[N_SRC-1:0];
        end
        pending_d    = (pending_q & ~pend_clr) | rise | sw_set;
        overrun_d    = (overrun_q & ~ovr_clr) | (rise & pending_q & ~pend_clr);
        interrupts_d = pending_d & mask_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q    <= '0;
            mask_q       <= '0;
            overrun_q    <= '0;
            interrupts_q <= '0;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            overrun_q    <= overrun_d;
            interrupts_q <= interrupts_d;
        end
    end

    assign interrupts = interrupts_q;
    assign irq_valid  = |interrupts_q;
    assign irq_id     = prio_enc(interrupts_q);

    always_comb begin
        readdata = 32'h0;
        if      (dataadr == BASE + OFF_PENDING) readdata = {24'h0, pending_q};
        else if (dataadr == BASE + OFF_MASK)    readdata = {24'h0, mask_q};
        else if (dataadr == BASE + OFF_OVERRUN) readdata = {24'h0, overrun_q};
        else if (dataadr == BASE + OFF_ACTIVE)  readdata = {irq_valid, 28'h0, irq_id};
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations are queued with each stimulus step and
// popped when the corresponding output is sampled.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;
    localparam logic [31:0] A_PEND = BASE + 32'h00;
    localparam logic [31:0] A_MASK = BASE + 32'h04;
    localparam logic [31:0] A_OVR  = BASE + 32'h08;
    localparam logic [31:0] A_ACT  = BASE + 32'h0C;
    localparam logic [31:0] A_SWS  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  irq_in = '0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        memwrite = 1'b0;
    logic [31:0] readdata;
    logic [7:0]  interrupts;
    logic [2:0]  irq_id;
    logic        irq_valid;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int errors = 0;
    int checks = 0;

    irq_ctrl #(.BASE(BASE), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_in     (irq_in),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .memwrite   (memwrite),
        .readdata   (readdata),
        .interrupts (interrupts),
        .irq_id     (irq_id),
        .irq_valid  (irq_valid)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb.push_back(it);
    endtask

    task automatic chk(input logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        dataadr   = addr;
        writedata = data;
        tick();
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        dataadr = addr;
        #1;
        data = readdata;
        dataadr = '0;
    endtask

    task automatic pulse(input logic [7:0] bits);
        irq_in = bits;
        tick();
        irq_in = '0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] ints,
                              input logic [2:0] id, input logic vld);
        expect_val({tag, "_interrupts"}, {24'h0, ints});
        chk({24'h0, interrupts});
        expect_val({tag, "_irq_id"}, {29'h0, id});
        chk({29'h0, irq_id});
        expect_val({tag, "_irq_valid"}, {31'h0, vld});
        chk({31'h0, irq_valid});
    endtask

    task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        expect_val(tag, exp);
        bus_read(addr, rd);
        chk(rd);
    endtask

    initial begin
        // Reset state
        #2;
        check_outs("reset", 8'h00, 3'd0, 1'b0);
        check_reg("reset_pending", A_PEND, 32'h0);
        check_reg("reset_mask", A_MASK, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Single pulse on bit 1, three-cycle latency
        bus_write(A_MASK, 32'h02);
        pulse(8'h02);
        tick();
        check_outs("lat_early", 8'h00, 3'd0, 1'b0);
        tick();
        check_outs("pulse1", 8'h02, 3'd1, 1'b1);
        check_reg("active1", A_ACT, 32'h8000_0001);
        bus_write(A_PEND, 32'h02);
        check_outs("clear1", 8'h00, 3'd0, 1'b0);

        // Two simultaneous sources, priority, W1C next-cycle drop
        bus_write(A_MASK, 32'hFF);
        pulse(8'h03);
        tick();
        tick();
        check_outs("dual", 8'h03, 3'd0, 1'b1);
        bus_write(A_PEND, 32'h01);
        check_outs("dual_w1c", 8'h02, 3'd1, 1'b1);
        bus_write(A_PEND, 32'h02);

        // Masked source stays pending; unmask takes effect next cycle
        bus_write(A_MASK, 32'h00);
        pulse(8'h08);
        tick();
        tick();
        check_outs("masked", 8'h00, 3'd0, 1'b0);
        check_reg("masked_pending", A_PEND, 32'h08);
        bus_write(A_MASK, 32'h08);
        check_outs("unmask", 8'h08, 3'd3, 1'b1);
        bus_write(A_PEND, 32'h08);

        // Overrun after two pulses nine cycles apart
        bus_write(A_MASK, 32'hFF);
        pulse(8'h02);
        for (int i = 0; i < 8; i++) tick();
        pulse(8'h02);
        tick();
        tick();
        tick();
        check_reg("overrun_set", A_OVR, 32'h02);
        check_reg("overrun_pend", A_PEND, 32'h02);
        bus_write(A_OVR, 32'h02);
        check_reg("overrun_clr", A_OVR, 32'h00);
        bus_write(A_PEND, 32'h02);
        check_reg("pend_empty", A_PEND, 32'h00);

        // Set beats clear when rise[2] meets a W1C of bit 2
        pulse(8'h04);
        tick();
        bus_write(A_PEND, 32'h04);
        check_reg("set_wins", A_PEND, 32'h04);
        check_reg("no_overrun", A_OVR, 32'h00);
        bus_write(A_SWS, 32'h80);
        check_reg("swset", A_PEND, 32'h84);
        check_outs("swset_out", 8'h84, 3'd2, 1'b1);
        check_reg("swset_read0", A_SWS, 32'h0);
        check_reg("unmapped", BASE + 32'h14, 32'h0);
        bus_write(BASE - 32'h4, 32'h00);
        bus_write(BASE + 32'h104, 32'h00);
        check_reg("outside_write", A_MASK, 32'hFF);

        // Asynchronous reset mid-operation
        bus_write(A_SWS, 32'hFF);
        check_outs("all_pend", 8'hFF, 3'd0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("async_rst", 8'h00, 3'd0, 1'b0);
        check_reg("async_rst_pend", A_PEND, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        check_reg("post_rst_pend", A_PEND, 32'h0);
        check_reg("post_rst_mask", A_MASK, 32'h0);
        check_reg("post_rst_ovr", A_OVR, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter BASE, default 32'hFFFF_FF00, is the word-aligned base address of the register window.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops per irq_in bit (legal values 0..3).
REQ-003 Port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-004 Port reset_n, input, 1: reset is asynchronous and active-low.
REQ-005 Port irq_in, input, 8: raw interrupt request lines; a request is a rising edge, and a pulse may be as short as one cycle.
REQ-006 Port dataadr, input, 32: processor data bus address.
REQ-007 Port writedata, input, 32: processor store data.
REQ-008 Port memwrite, input, 1: store strobe, valid for one cycle.
REQ-009 Port readdata, output, 32: register read data, combinational from dataadr.
REQ-010 Port interrupts, output, 8: registered request lines, one per source, driven into the processor's interrupt inputs.
REQ-011 Port irq_id, output, 3: index of the highest-priority active source.
REQ-012 Port irq_valid, output, 1: high when any bit of interrupts is set.

Function
REQ-013 Each irq_in bit shall pass through SYNC_STAGES flops, then an edge register; rise = sync & ~edge_q.
REQ-014 Register map, where hit means dataadr == BASE + offset:
- 0x00 PENDING[7:0]: read / write-1-to-clear.
- 0x04 MASK[7:0]: read/write.
- 0x08 OVERRUN[7:0]: read / write-1-to-clear.
- 0x0C ACTIVE: bit 31 = irq_valid, bits 2:0 = irq_id, read-only.
- 0x10 SWSET: write-only; a 1 in any bit sets the corresponding PENDING bit.
REQ-015 Unmapped reads, reads of SWSET, and register bits 31:8 (except ACTIVE bit 31) shall return 0; writes outside the window shall be ignored.
REQ-016 PENDING[i] shall be set by rise[i] or by a SWSET write with bit i = 1, and cleared by a PENDING write with bit i = 1.
REQ-017 When a set and a clear hit the same bit in the same cycle, the set shall win.
REQ-018 OVERRUN[i] shall be set when rise[i] occurs while PENDING[i] is already 1 and is not being cleared in that cycle; OVERRUN is cleared by W1C.
REQ-019 interrupts shall be registered: interrupts <= PENDING_next & MASK_next.
REQ-020 With SYNC_STAGES = 2, an irq_in edge sampled at cycle N shall appear on interrupts at cycle N+3.
REQ-021 A PENDING W1C store at cycle N shall drop the corresponding interrupts bit at cycle N+1.
REQ-022 irq_id shall be the lowest index i with interrupts[i] = 1 (bit 0 has highest priority), and 0 when irq_valid = 0.
REQ-023 A MASK write shall take effect on interrupts the next cycle; masking a source shall not clear its PENDING bit.
REQ-024 readdata shall reflect register state before any same-cycle write.

Reset
REQ-025 While reset_n = 0, every register shall be 0: sync flops, edge_q, PENDING, MASK, OVERRUN and interrupts. As a result irq_id = 0 and irq_valid = 0.
REQ-026 An edge on irq_in coincident with the release of reset shall not be recorded until the synchronizer has refilled; no spurious pending bit shall be recorded.
REQ-027 Reset asserted mid-operation shall discard all pending and overrun state immediately, asynchronously.

Structure
REQ-028 The register offsets (0x00..0x10) and the source count (8) shall be localparams in a shared package, irq_pkg.
REQ-029 A per-bit synchronizer plus edge detector shall be one sub-module, irq_sync_edge, instantiated 8 times.
REQ-030 The target size is 150-250 lines of RTL.

Verification
REQ-031 One-cycle pulse on irq_in[1] with MASK = 0x02 -> interrupts = 0x02 three cycles later; irq_id = 1; irq_valid = 1; ACTIVE reads 0x8000_0001.
REQ-032 Pulses on irq_in[1] and irq_in[0] in the same cycle, MASK = 0xFF -> interrupts = 0x03 and irq_id = 0; then a store of 0x01 to BASE+0x00 -> interrupts = 0x02 and irq_id = 1 the next cycle.
REQ-033 MASK = 0x00 and a pulse on irq_in[3] -> interrupts stays 0x00 and PENDING reads 0x08; then MASK = 0x08 -> interrupts = 0x08 one cycle after the store.
REQ-034 Two pulses on irq_in[1] spaced 9 cycles apart, with no clear in between -> OVERRUN reads 0x02; a store of 0x02 to BASE+0x08 -> OVERRUN reads 0x00.
REQ-035 A PENDING W1C of 0x04 in the same cycle as rise[2] -> PENDING[2] remains 1; a separate SWSET store of 0x80 -> PENDING reads 0x80 (plus any previously pending bits) the next cycle.
REQ-036 Assert reset_n = 0 with PENDING = 0xFF and MASK = 0xFF -> all outputs 0 within the same cycle; after release, PENDING reads 0x00.
